data_io_upload: RTL and testbench

SPI-slave upload engine for the MiST I/O controller link, the read direction of the file-download path. On host command it streams bytes from a core-side RAM (save RAM, memory card image) out on the SPI data-out line, MSB first. The SPI inputs are oversampled in the core clock domain, so the block has one clock and sits beside the download receiver on the shared SPI pins.

---
 rtl/data_io_upload.sv | 192 +++++++++++++++++++
 tb/tb_data_io_upload.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_io_upload.sv
// SPI-slave upload engine: streams core RAM bytes to the I/O controller, MSB first,
// on the shared oversampled SPI pins (command 0x57 opens/closes a session, 0x58 reads data).
module data_io_upload #(
    parameter logic [14:0] START_ADDR  = 15'h0000,
    parameter int          CLK_DIV_MIN = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sck,
    input  logic        ss,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_en,
    input  logic [15:0] size,
    output logic        rd_req,
    output logic [14:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        uploading,
    output logic [15:0] tx_count
);

    localparam logic [7:0] CMD_FILE_RX     = 8'h57;
    localparam logic [7:0] CMD_FILE_RX_DAT = 8'h58;

    // A ratio below 8 leaves no room for the fetch to land before the next sck fall.
    if (CLK_DIV_MIN < 8) begin : g_sck_ratio_below_budget
    end

    // sck_q: [0]/[1] synchronizer stages, [2] previous synced value for edge detection
    logic [2:0]  sck_q;
    logic [1:0]  ss_q;
    logic [1:0]  sdi_q;

    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        fresh_q, fresh_d;
    logic        real_q, real_d;
    logic        rd_req_q, rd_req_d;
    logic        load_q, load_d;
    logic        up_q, up_d;
    logic [14:0] addr_q, addr_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] size_q, size_d;

    logic        ss_s, sdi_s;
    logic        sck_rise, sck_fall;
    logic        bit_edge;
    logic [7:0]  rx_byte;
    logic        data_phase;
    logic        prefetch, next_byte, start_ctl;

    assign ss_s       = ss_q[1];
    assign sdi_s      = sdi_q[1];
    assign sck_rise   = sck_q[1] & ~sck_q[2];
    assign sck_fall   = ~sck_q[1] & sck_q[2];
    assign bit_edge   = sck_rise & ~ss_s;
    assign rx_byte    = {rx_q[6:0], sdi_s};
    assign data_phase = (cmd_q == CMD_FILE_RX_DAT) && (cnt_q >= 5'd8);

    assign prefetch   = bit_edge && (cnt_q == 5'd7)  && (rx_byte == CMD_FILE_RX_DAT);
    assign next_byte  = bit_edge && (cnt_q == 5'd15) && (cmd_q == CMD_FILE_RX_DAT);
    assign start_ctl  = bit_edge && (cnt_q == 5'd15) && (cmd_q == CMD_FILE_RX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_q <= '0;
            ss_q  <= '1;
            sdi_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the pre-edge value, so the chain really delays.
            sck_q <= {sck_q[1:0], sck};
            ss_q  <= {ss_q[0], ss};
            sdi_q <= {sdi_q[0], sdi};
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first; a path that skips an assignment would otherwise infer a latch.
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        rx_d     = rx_q;
        shreg_d  = shreg_q;
        fresh_d  = fresh_q;
        real_d   = real_q;
        rd_req_d = 1'b0;
        load_d   = rd_req_q;
        up_d     = up_q;
        addr_d   = addr_q;
        tx_d     = tx_q;
        size_d   = size_q;

        if (ss_s) begin
            // Deselect drops any partial byte; address and tx_count keep their last committed values.
            cnt_d   = '0;
            cmd_d   = '0;
            fresh_d = 1'b0;
            real_d  = 1'b0;
            load_d  = 1'b0;
        end else begin
            if (sck_rise) begin
                rx_d  = rx_byte;
                cnt_d = (cnt_q == 5'd15) ? 5'd8 : 5'(cnt_q + 5'd1);
                if (cnt_q == 5'd7) begin
                    cmd_d = rx_byte;
                end
            end

            if (start_ctl) begin
                if (sdi_s) begin
                    up_d   = 1'b1;
                    addr_d = START_ADDR;
                    tx_d   = '0;
                    size_d = size;
                end else begin
                    up_d = 1'b0;
                end
            end

            if (next_byte && real_q) begin
                addr_d = 15'(addr_q + 15'd1);
                if (tx_q < size_q) begin
                    tx_d = 16'(tx_q + 16'd1);
                end
            end

            if (sck_fall && data_phase) begin
                if (fresh_q) begin
                    fresh_d = 1'b0;
                end else begin
                    shreg_d = {shreg_q[6:0], 1'b0};
                end
            end

            // tx_d already reflects the byte that just completed, so the limit test sees the new count.
            if (prefetch || next_byte) begin
                if (up_q && (tx_d < size_q)) begin
                    rd_req_d = 1'b1;
                    real_d   = 1'b1;
                end else begin
                    real_d  = 1'b0;
                    shreg_d = '0;
                    fresh_d = 1'b1;
                end
            end

            if (load_q) begin
                shreg_d = rd_data;
                fresh_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            cmd_q    <= '0;
            rx_q     <= '0;
            shreg_q  <= '0;
            fresh_q  <= 1'b0;
            real_q   <= 1'b0;
            rd_req_q <= 1'b0;
            load_q   <= 1'b0;
            up_q     <= 1'b0;
            addr_q   <= START_ADDR;
            tx_q     <= '0;
            size_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            rx_q     <= rx_d;
            shreg_q  <= shreg_d;
            fresh_q  <= fresh_d;
            real_q   <= real_d;
            rd_req_q <= rd_req_d;
            load_q   <= load_d;
            up_q     <= up_d;
            addr_q   <= addr_d;
            tx_q     <= tx_d;
            size_q   <= size_d;
        end
    end

    assign sdo_en    = ~ss_s & data_phase;
    assign sdo       = sdo_en & shreg_q[7];
    assign rd_req    = rd_req_q;
    assign rd_addr   = addr_q;
    assign uploading = up_q;
    assign tx_count  = tx_q;

endmodule

// File: tb/tb_data_io_upload.sv
// Bench for data_io_upload: an SPI host model drives sessions, and a byte-level model
// of the upload session (address, count, limit) predicts every byte and counter.
module tb_data_io_upload;

    localparam int          HALF  = 6;
    localparam logic [14:0] START = 15'h0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck = 1'b0;
    logic        ss = 1'b1;
    logic        sdi = 1'b0;
    logic        sdo, sdo_en;
    logic [15:0] size = 16'd0;
    logic        rd_req;
    logic [14:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic        uploading;
    logic [15:0] tx_count;

    data_io_upload #(.START_ADDR(START), .CLK_DIV_MIN(8)) dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
        .sdo(sdo), .sdo_en(sdo_en), .size(size),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .uploading(uploading), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:32767];
    int   rd_count = 0;
    logic rd_prev = 1'b0;
    logic dbl_rd = 1'b0;

    always @(posedge clk) begin
        rd_data  <= rd_req ? mem[rd_addr] : 8'($urandom);
        rd_prev  <= rd_req;
        if (rd_req) rd_count <= rd_count + 1;
        if (rd_req && rd_prev) dbl_rd <= 1'b1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    // session model
    bit m_up = 1'b0;
    int m_addr = 0;
    int m_tx = 0;
    int m_size = 0;

    logic [7:0] tx_buf [16];
    logic [7:0] rx_buf [16];
    logic [7:0] exp_buf [16];
    logic       en_all_buf [16];
    logic       en_any_buf [16];
    logic       cmd_en_any;

    task automatic spi_bit(input logic b, output logic r, output logic e);
        sdi = b;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        r = sdo;
        e = sdo_en;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r,
                            output logic en_all, output logic en_any);
        logic rb, eb;
        r = '0;
        en_all = 1'b1;
        en_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], rb, eb);
            r[i] = rb;
            en_all &= eb;
            en_any |= eb;
        end
    endtask

    task automatic xact(input logic [7:0] cmd, input int n, input int part_bits);
        logic [7:0] r;
        logic ea, rb, eb;
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(cmd, r, ea, cmd_en_any);
        for (int k = 0; k < n; k++)
            spi_byte(tx_buf[k], rx_buf[k], en_all_buf[k], en_any_buf[k]);
        for (int b = 0; b < part_bits; b++)
            spi_bit(1'b1, rb, eb);
        repeat (HALF) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Byte positions 0..n are each fetched; only the n complete ones advance the session.
    task automatic model_data(input int n, output int reads);
        bit real_byte;
        reads = 0;
        for (int k = 0; k <= n; k++) begin
            real_byte = m_up && (m_tx < m_size);
            if (real_byte) reads++;
            if (k < n) begin
                exp_buf[k] = real_byte ? mem[m_addr] : 8'h00;
                if (real_byte) begin
                    m_addr = (m_addr + 1) & 32'h7fff;
                    m_tx++;
                end
            end
        end
    endtask

    task automatic start_session(input bit on);
        int r0;
        r0 = rd_count;
        tx_buf[0] = on ? 8'h01 : 8'h00;
        xact(8'h57, 1, 0);
        if (on) begin
            m_up = 1'b1; m_addr = START; m_tx = 0; m_size = size;
        end else begin
            m_up = 1'b0;
        end
        n_cmp++;
        if (uploading !== m_up) begin
            n_fail++; $display("FAIL start_uploading: got %b expected %b", uploading, m_up);
        end
        n_cmp++;
        if (tx_count !== 16'(m_tx)) begin
            n_fail++; $display("FAIL start_tx_count: got %0d expected %0d", tx_count, m_tx);
        end
        n_cmp++;
        if (rd_count - r0 !== 0) begin
            n_fail++; $display("FAIL start_rd_req: got %0d pulses expected 0", rd_count - r0);
        end
    endtask

    task automatic data_session(input string tag, input int n, input int part);
        int r0, reads;
        r0 = rd_count;
        for (int k = 0; k < n; k++) tx_buf[k] = 8'($urandom);
        xact(8'h58, n, part);
        model_data(n, reads);
        for (int k = 0; k < n; k++) begin
            n_cmp++;
            if (rx_buf[k] !== exp_buf[k]) begin
                n_fail++; $display("FAIL %s byte%0d sdo: got %h expected %h", tag, k, rx_buf[k], exp_buf[k]);
            end
            n_cmp++;
            if (en_all_buf[k] !== 1'b1) begin
                n_fail++; $display("FAIL %s byte%0d sdo_en: got %b expected 1", tag, k, en_all_buf[k]);
            end
        end
        n_cmp++;
        if (tx_count !== 16'(m_tx)) begin
            n_fail++; $display("FAIL %s tx_count: got %0d expected %0d", tag, tx_count, m_tx);
        end
        n_cmp++;
        if (rd_addr !== 15'(m_addr)) begin
            n_fail++; $display("FAIL %s rd_addr: got %h expected %h", tag, rd_addr, 15'(m_addr));
        end
        n_cmp++;
        if (rd_count - r0 !== reads) begin
            n_fail++; $display("FAIL %s rd_req_count: got %0d expected %0d", tag, rd_count - r0, reads);
        end
        n_cmp++;
        if (uploading !== m_up) begin
            n_fail++; $display("FAIL %s uploading: got %b expected %b", tag, uploading, m_up);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({sdo, sdo_en, rd_req, uploading} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {sdo, sdo_en, rd_req, uploading});
        end
        n_cmp++;
        if (rd_addr !== START) begin
            n_fail++; $display("FAIL reset_rd_addr: got %h expected %h", rd_addr, START);
        end
        n_cmp++;
        if (tx_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_tx_count: got %0d expected 0", tx_count);
        end
    endtask

    task automatic test_upload_3();
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF;
        size = 16'd3;
        start_session(1'b1);
        data_session("three_bytes", 3, 0);
    endtask

    task automatic test_past_end();
        start_session(1'b1);
        data_session("past_end", 5, 0);
    endtask

    task automatic test_abort();
        start_session(1'b1);
        data_session("abort", 1, 4);
        data_session("resume", 2, 0);
    endtask

    task automatic test_foreign();
        int r0;
        start_session(1'b1);
        data_session("pre_foreign", 1, 0);
        r0 = rd_count;
        for (int k = 0; k < 3; k++) tx_buf[k] = 8'($urandom);
        xact(8'h54, 3, 0);
        n_cmp++;
        if (cmd_en_any | en_any_buf[0] | en_any_buf[1] | en_any_buf[2]) begin
            n_fail++; $display("FAIL foreign_sdo_en: got 1 expected 0");
        end
        n_cmp++;
        if ((rx_buf[0] | rx_buf[1] | rx_buf[2]) !== 8'h00) begin
            n_fail++; $display("FAIL foreign_sdo: got %h expected 00", rx_buf[0] | rx_buf[1] | rx_buf[2]);
        end
        n_cmp++;
        if (rd_count - r0 !== 0) begin
            n_fail++; $display("FAIL foreign_rd_req: got %0d expected 0", rd_count - r0);
        end
        n_cmp++;
        if ({uploading, tx_count, rd_addr} !== {m_up, 16'(m_tx), 15'(m_addr)}) begin
            n_fail++; $display("FAIL foreign_state: got %b/%0d/%h expected %b/%0d/%h",
                               uploading, tx_count, rd_addr, m_up, m_tx, 15'(m_addr));
        end
        data_session("post_foreign", 2, 0);
    endtask

    task automatic test_end();
        start_session(1'b0);
        data_session("ended", 2, 0);
    endtask

    task automatic test_mid_reset();
        logic [7:0] r;
        logic ea, ey, rb, eb;
        mem[0] = 8'h81; mem[1] = 8'hC3; mem[2] = 8'h7E;
        size = 16'd3;
        start_session(1'b1);
        data_session("pre_reset", 1, 0);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'h58, r, ea, ey);
        spi_bit(1'b0, rb, eb);
        repeat (HALF) @(negedge clk);
        n_cmp++;
        if ({sdo, sdo_en} !== 2'b11) begin
            n_fail++; $display("FAIL pre_reset_sdo: got %b expected 11", {sdo, sdo_en});
        end
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({sdo, sdo_en, rd_req, uploading} !== 4'b0000) begin
            n_fail++; $display("FAIL mid_reset_flags: got %b expected 0000", {sdo, sdo_en, rd_req, uploading});
        end
        n_cmp++;
        if ({tx_count, rd_addr} !== {16'd0, START}) begin
            n_fail++; $display("FAIL mid_reset_counters: got %0d/%h expected 0/%h", tx_count, rd_addr, START);
        end
        reset_n = 1'b1;
        ss = 1'b1;
        repeat (8) @(negedge clk);
        m_up = 1'b0; m_addr = START; m_tx = 0; m_size = 0;
        data_session("post_reset", 1, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
            size = 16'($urandom_range(0, 6));
            start_session(1'b1);
            for (int s = 0; s < 2; s++)
                data_session($sformatf("rand%0d_%0d", it, s), $urandom_range(0, 5), $urandom_range(0, 7));
        end
    endtask

    task automatic test_rd_strobe();
        n_cmp++;
        if (dbl_rd !== 1'b0) begin
            n_fail++; $display("FAIL rd_req_width: got multi-cycle strobe expected single-cycle");
        end
    endtask

    initial begin
        test_reset();
        test_upload_3();
        test_past_end();
        test_abort();
        test_foreign();
        test_end();
        test_mid_reset();
        test_random();
        test_rd_strobe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
